// File: rtl/timer_counter_unit_pkg.sv
// Shared definitions for the machine timer unit: register offsets, FSM states,
// reset constants and the byte-masked merge helper.
package timer_counter_unit_pkg;

    localparam int unsigned TIMER_XLEN = 32;
    localparam int unsigned TIMER_CW   = 64;

    localparam logic [3:0] TIMER_OFF_MTIME_LO    = 4'h0;
    localparam logic [3:0] TIMER_OFF_MTIME_HI    = 4'h4;
    localparam logic [3:0] TIMER_OFF_MTIMECMP_LO = 4'h8;
    localparam logic [3:0] TIMER_OFF_MTIMECMP_HI = 4'hC;

    localparam logic [TIMER_CW-1:0] TIMER_MTIMECMP_RST = {TIMER_CW{1'b1}};

    typedef enum logic {
        TIMER_IDLE = 1'b0,
        TIMER_RESP = 1'b1
    } timer_state_e;

    // new = (old & ~M) | (wdata & M) with M the byte-expanded write mask
    function automatic logic [TIMER_XLEN-1:0] timer_apply_mask(
        input logic [TIMER_XLEN-1:0] old_val,
        input logic [TIMER_XLEN-1:0] wdata,
        input logic [3:0]            wmask
    );
        logic [TIMER_XLEN-1:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{wmask[i]}};
        end
        return (old_val & ~m) | (wdata & m);
    endfunction

endpackage

// File: rtl/timer_counter_unit_prescaler.sv
// Divides the core clock down to a 1 MHz tick; tick is high in the cycle the
// counter sits at FMAX_MHz-1 (every cycle when FMAX_MHz == 1).
module timer_prescaler #(
    parameter int unsigned FMAX_MHz = 27
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (FMAX_MHz > 1) ? $clog2(FMAX_MHz) : 1;
    localparam logic [CW-1:0] LAST = CW'(FMAX_MHz - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    // tick_q is registered against the counter value it will describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= (FMAX_MHz == 1);
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/timer_counter_unit.sv
// Machine timer / cycle counter with a 32-bit memory-mapped window onto
// mtime and mtimecmp; feeds the CSR stage with counter and pending state.
module timer_counter_unit
    import timer_counter_unit_pkg::*;
#(
    parameter int unsigned FMAX_MHz  = 27,
    parameter logic [31:0] BASE_ADDR = 32'hf0000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic        mem_resp_valid,
    output logic [31:0] mem_rdata,
    output logic [63:0] reg_cycle,
    output logic [63:0] reg_time,
    output logic [63:0] reg_mtime,
    output logic [63:0] reg_mtimecmp,
    output logic        timer_pending
);

    timer_state_e          state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [TIMER_XLEN-1:0] rdata_q, rdata_d;
    logic [TIMER_CW-1:0]   cycle_q, cycle_d;
    logic [TIMER_CW-1:0]   mtime_q, mtime_d;
    logic [TIMER_CW-1:0]   mtimecmp_q, mtimecmp_d;
    logic                  pending_q, pending_d;
    logic                  tick;
    logic                  hit;
    logic [3:0]            off;
    logic                  unused_addr_bits;

    timer_prescaler #(
        .FMAX_MHz (FMAX_MHz)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign hit              = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign off              = {mem_addr[3:2], 2'b00};
    assign unused_addr_bits = ^mem_addr[1:0];

    // Request FSM plus register next-state; a write to a half pre-empts the tick
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        cycle_d    = cycle_q + 64'd1;
        mtime_d    = tick ? (mtime_q + 64'd1) : mtime_q;
        mtimecmp_d = mtimecmp_q;

        unique case (state_q)
            TIMER_IDLE: begin
                if (mem_valid) begin
                    state_d = TIMER_RESP;
                    if (mem_wen) begin
                        rdata_d = '0;
                        if (hit) begin
                            unique case (off)
                                TIMER_OFF_MTIME_LO: mtime_d = {mtime_q[63:32],
                                    timer_apply_mask(mtime_q[31:0], mem_wdata, mem_wmask)};
                                TIMER_OFF_MTIME_HI: mtime_d = {
                                    timer_apply_mask(mtime_q[63:32], mem_wdata, mem_wmask),
                                    mtime_q[31:0]};
                                TIMER_OFF_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32],
                                    timer_apply_mask(mtimecmp_q[31:0], mem_wdata, mem_wmask)};
                                default: mtimecmp_d = {
                                    timer_apply_mask(mtimecmp_q[63:32], mem_wdata, mem_wmask),
                                    mtimecmp_q[31:0]};
                            endcase
                        end
                    end else if (hit) begin
                        unique case (off)
                            TIMER_OFF_MTIME_LO:    rdata_d = mtime_q[31:0];
                            TIMER_OFF_MTIME_HI:    rdata_d = mtime_q[63:32];
                            TIMER_OFF_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                            default:               rdata_d = mtimecmp_q[63:32];
                        endcase
                    end else begin
                        rdata_d = '0;
                    end
                end
            end
            TIMER_RESP: begin
                state_d = TIMER_IDLE;
            end
            default: begin
                state_d = TIMER_IDLE;
            end
        endcase

        ready_d      = (state_d == TIMER_IDLE);
        resp_valid_d = (state_d == TIMER_RESP);
        pending_d    = (mtime_d >= mtimecmp_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= TIMER_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            cycle_q      <= '0;
            mtime_q      <= '0;
            mtimecmp_q   <= TIMER_MTIMECMP_RST;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            cycle_q      <= cycle_d;
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            pending_q    <= pending_d;
        end
    end

    assign mem_ready      = ready_q;
    assign mem_resp_valid = resp_valid_q;
    assign mem_rdata      = rdata_q;
    assign reg_cycle      = cycle_q;
    assign reg_time       = mtime_q;
    assign reg_mtime      = mtime_q;
    assign reg_mtimecmp   = mtimecmp_q;
    assign timer_pending  = pending_q;

endmodule

// File: tb/tb_timer_counter_unit.sv
// Directed and random bus traffic against a cycle-level behavioural model of
// the timer window (prescaler derived from the cycle count).
module tb_timer_counter_unit;

    localparam int unsigned F    = 4;
    localparam logic [31:0] BASE = 32'hf0000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic [63:0] reg_cycle, reg_time, reg_mtime, reg_mtimecmp;
    logic        timer_pending;

    timer_counter_unit #(
        .FMAX_MHz  (F),
        .BASE_ADDR (BASE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .reg_cycle      (reg_cycle),
        .reg_time       (reg_time),
        .reg_mtime      (reg_mtime),
        .reg_mtimecmp   (reg_mtimecmp),
        .timer_pending  (timer_pending)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] m_cycle, m_mtime, m_cmp;
    logic [31:0] m_rdata;
    logic        m_busy, m_pend;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cycle = '0;
        m_mtime = '0;
        m_cmp   = '1;
        m_rdata = '0;
        m_busy  = 1'b0;
        m_pend  = 1'b0;
    endtask

    task automatic check_all();
        chk("ready",      64'(mem_ready),      64'(!m_busy));
        chk("resp_valid", 64'(mem_resp_valid), 64'(m_busy));
        chk("rdata",      64'(mem_rdata),      64'(m_rdata));
        chk("cycle",      reg_cycle,           m_cycle);
        chk("mtime",      reg_mtime,           m_mtime);
        chk("time",       reg_time,            m_mtime);
        chk("mtimecmp",   reg_mtimecmp,        m_cmp);
        chk("pending",    64'(timer_pending),  64'(m_pend));
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Entered at a falling edge; leaves at the next falling edge after checking.
    task automatic step(input logic v, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
        logic         acc, tick, hit;
        logic [1:0]   idx;
        logic [63:0]  n_mtime, n_cmp;
        logic [127:0] regs;
        mem_valid = v; mem_wen = w; mem_addr = a; mem_wdata = d; mem_wmask = m;
        acc     = v && !m_busy;
        tick    = (m_cycle % 64'(F)) == 64'(F - 1);
        hit     = (a[31:4] == BASE[31:4]);
        idx     = a[3:2];
        regs    = {m_cmp, m_mtime};
        n_mtime = tick ? m_mtime + 64'd1 : m_mtime;
        n_cmp   = m_cmp;
        if (acc) begin
            if (w) begin
                m_rdata = '0;
                if (hit) begin
                    case (idx)
                        2'd0: n_mtime = {m_mtime[63:32], merge(m_mtime[31:0], d, m)};
                        2'd1: n_mtime = {merge(m_mtime[63:32], d, m), m_mtime[31:0]};
                        2'd2: n_cmp   = {m_cmp[63:32], merge(m_cmp[31:0], d, m)};
                        default: n_cmp = {merge(m_cmp[63:32], d, m), m_cmp[31:0]};
                    endcase
                end
            end else begin
                m_rdata = hit ? regs[32*idx +: 32] : 32'd0;
            end
        end
        @(posedge clk);
        #1;
        m_mtime = n_mtime;
        m_cmp   = n_cmp;
        m_pend  = (n_mtime >= n_cmp);
        m_busy  = acc;
        m_cycle = m_cycle + 64'd1;
        check_all();
        @(negedge clk);
        mem_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    // Park so that the next rising edge is a tick edge.
    task automatic align_tick();
        for (int i = 0; i < 2 * F && (m_cycle % 64'(F)) != 64'(F - 1); i++) idle();
    endtask

    initial begin
        logic [63:0] saved_cmp;
        logic        prev_pend;
        logic [31:0] ra;
        int          guard;

        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-run 12 cycles out of reset
        for (int i = 0; i < 12; i++) idle();
        chk("run12_cycle", reg_cycle, 64'd12);
        chk("run12_mtime", reg_mtime, 64'd3);
        chk("run12_cmp",   reg_mtimecmp, 64'hffffffffffffffff);
        chk("run12_pend",  64'(timer_pending), 64'd0);

        // Compare point at 0x10, pending rises with the crossing
        step(1'b1, 1'b1, BASE + 32'h8, 32'h0000_0010, 4'hF); idle();
        step(1'b1, 1'b1, BASE + 32'hC, 32'h0, 4'hF); idle();
        guard = 0;
        prev_pend = timer_pending;
        while (m_mtime != 64'h10 && guard < 200) begin
            prev_pend = timer_pending;
            idle();
            guard++;
        end
        chk("cross_reached", 64'(guard < 200), 64'd1);
        chk("cross_prev",    64'(prev_pend), 64'd0);
        chk("cross_pend",    64'(timer_pending), 64'd1);

        // Write mtime low in a tick cycle: no increment
        align_tick();
        step(1'b1, 1'b1, BASE + 32'h0, 32'hDEADBEEF, 4'hF);
        chk("coll_lo", 64'(reg_mtime[31:0]), 64'hDEADBEEF);
        idle();
        align_tick();
        idle();
        chk("coll_next", 64'(reg_mtime[31:0]), 64'hDEADBEF0);

        // Byte-masked write to mtimecmp low
        step(1'b1, 1'b1, BASE + 32'h8, 32'hFFFFFFFF, 4'hF); idle();
        step(1'b1, 1'b1, BASE + 32'h8, 32'h0000AB00, 4'b0010);
        chk("mask_cmp", 64'(reg_mtimecmp[31:0]), 64'hFFFFABFF);
        idle();

        // mtime = 0x1_FFFFFFFF then read the high word
        step(1'b1, 1'b1, BASE + 32'h4, 32'h1, 4'hF); idle();
        align_tick();
        step(1'b1, 1'b1, BASE + 32'h0, 32'hFFFFFFFF, 4'hF); idle();
        step(1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'h0);
        chk("rd_hi_valid", 64'(mem_resp_valid), 64'd1);
        chk("rd_hi_data",  64'(mem_rdata), 64'h1);
        idle();

        // Out-of-window accesses
        step(1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'h0);
        chk("miss_rd", 64'(mem_rdata), 64'd0);
        idle();
        saved_cmp = reg_mtimecmp;
        step(1'b1, 1'b1, BASE + 32'h28, 32'h12345678, 4'hF);
        chk("miss_wr_cmp", reg_mtimecmp, saved_cmp);
        idle();

        // mem_valid held high: every other cycle accepted
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, BASE + 32'h0, 32'h0, 4'h0);
        idle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = $urandom;
                1:       ra = BASE + 32'($urandom_range(16, 63));
                default: ra = BASE + 32'($urandom_range(0, 15));
            endcase
            step(($urandom_range(0, 9) < 7), 1'($urandom), ra, $urandom, 4'($urandom));
        end

        // Reset asserted while a response is outstanding
        idle();
        step(1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0);
        chk("pre_rst_resp", 64'(mem_resp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) idle();
        step(1'b1, 1'b0, BASE + 32'hC, 32'h0, 4'h0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_counter_unit.md
Name: timer_counter_unit

Overview:
- Memory-mapped machine timer and counter source directly upstream of the CSR stage.
- Drives reg_cycle, reg_time, reg_mtime and reg_mtimecmp, which the CSR stage uses for counter CSR reads and timer-interrupt decisions.
- Exposes mtime/mtimecmp on a 32-bit memory-mapped port so software running on the core can program timer interrupts.
- Also produces a registered timer-pending flag.

Parameters:
- FMAX_MHz, 27: core clock in MHz. mtime ticks once every FMAX_MHz cycles (1 MHz). Legal range >= 1.
- BASE_ADDR, 32'hf0000000: base address of the register window. Must be 16-byte aligned.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_valid  in  1  request strobe.
- mem_ready  out  1  unit can accept a request this cycle.
- mem_wen  in  1  1 = write, 0 = read.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wmask  in  4  byte enables for writes; bit i covers bits 8i+7..8i.
- mem_resp_valid  out  1  response strobe, one cycle.
- mem_rdata  out  32  read data, valid with mem_resp_valid.
- reg_cycle  out  64  cycles since reset.
- reg_time  out  64  mirror of mtime.
- reg_mtime  out  64  current mtime.
- reg_mtimecmp  out  64  current mtimecmp.
- timer_pending  out  1  registered (mtime >= mtimecmp).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - cycle = 0, mtime = 0.
  - mtimecmp = 64'hffffffffffffffff, so no interrupt is pending out of reset.
  - prescaler = 0.
  - FSM = IDLE, mem_resp_valid = 0, mem_rdata = 0, timer_pending = 0.
- Reset asserted mid-transaction: the pending response is dropped and the FSM returns to IDLE.
- Register map (offset from BASE_ADDR):
  - 0x0 mtime[31:0]
  - 0x4 mtime[63:32]
  - 0x8 mtimecmp[31:0]
  - 0xC mtimecmp[63:32]
- Address decode:
  - A hit requires mem_addr[31:4] == BASE_ADDR[31:4].
  - mem_addr[1:0] is ignored; only word accesses are supported.
  - Any other address is a miss: reads return 0, writes are discarded, and a response is still given.
- cycle:
  - Increments by 1 every clock, wrapping 2^64-1 -> 0.
  - Not writable.
- Prescaler:
  - Counts 0..FMAX_MHz-1 and asserts tick when it equals FMAX_MHz-1, then wraps to 0.
  - With FMAX_MHz = 1, tick is asserted every cycle.
- mtime:
  - Increments by 1 on tick, wrapping 64-bit.
  - reg_time == reg_mtime at all times.
- Write/tick collision: a write to either mtime half in a tick cycle takes precedence.
  - The written half takes the masked write value.
  - The other half keeps its old value.
  - No increment is applied that cycle.
- Non-atomic 64-bit access: no carry protection across halves. Software uses the hi-lo-hi read sequence.
- FSM:
  - IDLE:
    - mem_ready = 1.
    - On mem_valid: latch the read data (read) or apply the masked write (write), then go to RESP.
  - RESP:
    - mem_ready = 0, mem_resp_valid = 1, mem_rdata holds the latched value.
    - Unconditionally returns to IDLE next cycle.
- Latency and throughput: response one cycle after acceptance. Throughput is one request per 2 cycles; mem_valid while mem_ready = 0 is ignored.
- Read data: the value of the register in the acceptance cycle, before that cycle's tick. For writes, mem_rdata = 0.
- Masked write: new = (old & ~M) | (wdata & M), where M is wmask expanded to bytes.
- timer_pending:
  - Registered compare of the next-state mtime and mtimecmp.
  - It therefore reflects a write one cycle after the write is accepted, and a crossing one cycle after the tick.
- Outputs reg_*: direct register outputs, no combinational path from the mem_* inputs.

Decomposition:
- Shared package:
  - register offsets (TIMER_OFF_MTIME_LO/HI, TIMER_OFF_MTIMECMP_LO/HI);
  - FSM state encodings (TIMER_IDLE, TIMER_RESP);
  - the mtimecmp reset constant.
- One sub-module, timer_prescaler (parameter FMAX_MHz; clk, rst_n; output tick).
- The rest stays flat.

Test Plan:
- Reset release with FMAX_MHz = 4 -> after 12 cycles, reg_cycle = 12, reg_mtime = 3, reg_mtimecmp = all ones, timer_pending = 0.
- Write 0x0000_0010 to offset 0x8 and 0x0 to offset 0xC; run mtime from 0 -> timer_pending rises exactly 1 cycle after the tick that makes mtime = 0x10.
- Write 0xDEADBEEF to offset 0x0 in a tick cycle -> mtime[31:0] = 0xDEADBEEF next cycle (no +1); the following tick gives 0xDEADBEF0.
- Write wmask = 4'b0010, wdata = 0x0000AB00 to offset 0x8 with old 0xFFFFFFFF -> mtimecmp[31:0] = 0xFFFFABFF.
- Read offset 0x4 with mtime = 0x1_FFFFFFFF -> mem_resp_valid 1 cycle later with mem_rdata = 0x1. Read of BASE_ADDR + 0x20 -> mem_rdata = 0; a write there changes nothing.
- Back-to-back mem_valid held high -> accepted every other cycle only. Assert rst_n = 0 during RESP -> mem_resp_valid drops immediately and all registers return to reset values.
